// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : ALU with a valid/ready handshake on both sides. Logic, add,
//               subtract and set-less-than finish in one cycle. Unsigned
//               multiply (shift-add) and unsigned divide (restoring) take
//               WIDTH cycles and share one WIDTH+1-bit adder.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SLT  = 4'b0111;
  localparam logic [3:0] c_OP_NOR  = 4'b1100;
  localparam logic [3:0] c_OP_NAND = 4'b1101;
  localparam logic [3:0] c_OP_MULU = 4'b1000;
  localparam logic [3:0] c_OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;      // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;    // partial product high half / remainder
  logic [WIDTH-1:0] lo_q, lo_d;    // multiplier bits / dividend then quotient
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             ill_q, ill_d;

  // Single-cycle datapath signals (computed straight from the inputs)
  logic             w_is_sub;
  logic [WIDTH:0]   w_as_sum;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic             w_slt;
  logic [WIDTH-1:0] w_sc_lo;
  logic [WIDTH-1:0] w_sc_hi;
  logic             w_sc_cout;
  logic             w_sc_ovf;
  logic             w_sc_dz;
  logic             w_sc_ill;
  logic             w_multi;
  logic             w_accept;

  // Iterative datapath signals
  logic             w_mul;
  logic [WIDTH:0]   w_it_lhs;
  logic [WIDTH:0]   w_it_rhs;
  logic [WIDTH:0]   w_it_sum;
  logic [WIDTH:0]   w_mul_s;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign w_accept   = in_valid && in_ready;

  assign result_lo  = res_lo_q;
  assign result_hi  = res_hi_q;
  assign zero       = zero_q;
  assign cout       = cout_q;
  assign overflow   = ovf_q;
  assign div_zero   = dz_q;
  assign illegal_op = ill_q;

  // Add/subtract shared by ADD, SUB and SLT; SLT corrects the sign with overflow
  always_comb begin
    w_is_sub  = (alu_op == c_OP_SUB) || (alu_op == c_OP_SLT);
    w_as_sum  = {1'b0, src1} + {1'b0, (w_is_sub ? ~src2 : src2)}
              + {{WIDTH{1'b0}}, w_is_sub};
    w_ovf_add = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                (w_as_sum[WIDTH-1] != src1[WIDTH-1]);
    w_ovf_sub = (src1[WIDTH-1] != src2[WIDTH-1]) &&
                (w_as_sum[WIDTH-1] != src1[WIDTH-1]);
    w_slt     = w_as_sum[WIDTH-1] ^ w_ovf_sub;
  end

  // Result and flags of any command that completes without iterating
  always_comb begin
    w_sc_lo   = '0;
    w_sc_hi   = '0;
    w_sc_cout = 1'b0;
    w_sc_ovf  = 1'b0;
    w_sc_dz   = 1'b0;
    w_sc_ill  = 1'b0;
    w_multi   = 1'b0;
    case (alu_op)
      c_OP_AND:  w_sc_lo = src1 & src2;
      c_OP_OR:   w_sc_lo = src1 | src2;
      c_OP_NOR:  w_sc_lo = ~(src1 | src2);
      c_OP_NAND: w_sc_lo = ~(src1 & src2);
      c_OP_ADD: begin
        w_sc_lo   = w_as_sum[WIDTH-1:0];
        w_sc_cout = w_as_sum[WIDTH];
        w_sc_ovf  = w_ovf_add;
      end
      c_OP_SUB: begin
        w_sc_lo   = w_as_sum[WIDTH-1:0];
        w_sc_cout = w_as_sum[WIDTH];
        w_sc_ovf  = w_ovf_sub;
      end
      c_OP_SLT:  w_sc_lo = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_MULU: w_multi = 1'b1;
      c_OP_DIVU: begin
        if (src2 == '0) begin
          w_sc_lo = '1;
          w_sc_hi = src1;
          w_sc_dz = 1'b1;
        end else begin
          w_multi = 1'b1;
        end
      end
      default:   w_sc_ill = 1'b1;
    endcase
  end

  // One iteration step; a single WIDTH+1-bit adder serves multiply and divide
  always_comb begin
    w_mul     = (op_q == c_OP_MULU);
    w_it_lhs  = w_mul ? {1'b0, hi_q} : {hi_q, lo_q[WIDTH-1]};
    w_it_rhs  = w_mul ? {1'b0, b_q} : ~{1'b0, b_q};
    w_it_sum  = w_it_lhs + w_it_rhs + {{WIDTH{1'b0}}, ~w_mul};
    // multiply: add the multiplicand when the current multiplier bit is set
    w_mul_s   = lo_q[0] ? w_it_sum : {1'b0, hi_q};
    // divide: top bit of the difference is the borrow (remainder < divisor)
    w_div_ok  = ~w_it_sum[WIDTH];
    if (w_mul) begin
      w_hi_next = w_mul_s[WIDTH:1];
      w_lo_next = {w_mul_s[0], lo_q[WIDTH-1:1]};
    end else begin
      w_hi_next = w_div_ok ? w_it_sum[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      w_lo_next = {lo_q[WIDTH-2:0], w_div_ok};
    end
  end

  // Next-state and next-register logic for the control FSM and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          op_d  = alu_op;
          b_d   = src2;
          lo_d  = src1;
          hi_d  = '0;
          cnt_d = '0;
          if (w_multi) begin
            state_d = BUSY;
          end else begin
            state_d  = DONE;
            res_lo_d = w_sc_lo;
            res_hi_d = w_sc_hi;
            zero_d   = (w_sc_lo == '0);
            cout_d   = w_sc_cout;
            ovf_d    = w_sc_ovf;
            dz_d     = w_sc_dz;
            ill_d    = w_sc_ill;
          end
        end
      end
      BUSY: begin
        hi_d  = w_hi_next;
        lo_d  = w_lo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == c_CNT_LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          res_lo_d = w_lo_next;
          res_hi_d = w_hi_next;
          zero_d   = (w_lo_next == '0);
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
          ill_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; legal values are 8 to 64.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  in  1  the command on src1, src2 and alu_op is valid.
REQ-005 Port: in_ready  out  1  the block accepts a command this cycle.
REQ-006 Port: src1, src2  in  WIDTH  operands.
REQ-007 Port: alu_op  in  4  opcodes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100, NAND=1101, MULU=1000, DIVU=1001.
REQ-008 Port: out_valid  out  1  the result and flags are valid.
REQ-009 Port: out_ready  in  1  the consumer takes the result this cycle.
REQ-010 Port: result_lo  out  WIDTH  primary result; for DIVU, the quotient.
REQ-011 Port: result_hi  out  WIDTH  MULU high product or DIVU remainder; 0 for all other ops.
REQ-012 Port: zero, cout, overflow, div_zero, illegal_op  out  1 each  status flags.

Function
REQ-013 States: IDLE, BUSY, DONE; in_ready=1 only in IDLE with rst low.
REQ-014 Accept when in_valid&&in_ready; latch src1, src2 and alu_op at that edge; inputs are ignored in any other cycle.
REQ-015 Single-cycle ops (logic, ADD, SUB, SLT, illegal op): IDLE->DONE at acceptance; out_valid is high the cycle after acceptance.
REQ-016 MULU and DIVU with a nonzero divisor: IDLE->BUSY; an iteration counter runs from 0 to WIDTH-1, one bit per cycle; BUSY->DONE after WIDTH cycles; out_valid rises WIDTH+1 cycles after acceptance.
REQ-017 DONE: out_valid=1; outputs are held stable until out_ready=1; DONE->IDLE on the out_ready edge; the next command can be accepted no earlier than the cycle after.
REQ-018 NOR = ~(a|b); NAND = ~(a&b); AND and OR are bitwise.
REQ-019 ADD computes a+b; SUB computes a+~b+1; cout = carry out of bit WIDTH-1.
REQ-020 overflow (ADD): operand signs equal and the result sign differs.
REQ-021 overflow (SUB): operand signs differ and the result sign differs from a.
REQ-022 cout and overflow are 0 for all other ops.
REQ-023 SLT: result_lo = 1 if signed a<b, else 0; the comparison is correct even when a-b overflows.
REQ-024 MULU: unsigned shift-add multiply; {result_hi,result_lo} = full 2*WIDTH-bit product.
REQ-025 DIVU: unsigned restoring divide; result_lo = quotient, result_hi = remainder.
REQ-026 DIVU by zero: no BUSY state; go to DONE next cycle with result_lo = all ones, result_hi = src1, div_zero=1.
REQ-027 Unlisted opcode: go to DONE next cycle with results 0, illegal_op=1, zero=1.
REQ-028 zero = (result_lo==0) for every op, including MULU and DIVU.
REQ-029 Outside DONE, out_valid=0; result and flag outputs keep their last values.
REQ-030 MULU and DIVU use no combinational multiplier or divider: one WIDTH+1-bit adder or subtractor per iteration.

Reset
REQ-031 While rst is high: state=IDLE, counter=0, in_ready=0, out_valid=0, all results and flags 0; the reset takes effect immediately, independent of clk.
REQ-032 Reset asserted in BUSY or DONE aborts the operation: no out_valid is produced for the aborted command, and the command is not replayed.
REQ-033 in_ready rises the first cycle rst is low.

Verification
REQ-034 ADD 0x7FFFFFFF+0x00000001 -> one cycle later out_valid=1, result_lo=0x80000000, overflow=1, cout=0, zero=0.
REQ-035 SUB 5-5 -> result_lo=0, zero=1, cout=1, overflow=0.
REQ-036 SLT 0x80000000 vs 0x00000001 -> result_lo=1; swapped operands -> result_lo=0.
REQ-037 MULU 0xFFFFFFFF*2 -> out_valid 33 cycles after acceptance, result_hi=1, result_lo=0xFFFFFFFE.
REQ-038 DIVU 100/7 -> result_lo=14, result_hi=2 after 33 cycles; DIVU 5/0 -> next cycle result_lo=0xFFFFFFFF, result_hi=5, div_zero=1.
REQ-039 Backpressure and reset: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; rst pulse at cycle 10 of a MULU -> no out_valid for that command, in_ready=1 the first cycle after rst falls.
